blinds_motor_controller: RTL and testbench

- Multi-channel successor to the combinational blinds decision logic in the smart-home controller.
- Drives NUM_CH blind motors with timed travel, position tracking, sunlight hysteresis, direction-reversal dead time and per-channel manual override with auto-resume.
- Sits between the sensor/clock aggregation logic (time, sunlight) and the motor driver pins.

---
 rtl/blinds_motor_controller_pkg.sv | 26 ++
 rtl/blinds_channel_fsm.sv | 133 +++++++++++++
 rtl/blinds_motor_controller.sv | 90 +++++++++
 tb/tb_blinds_motor_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blinds_motor_controller_pkg.sv
// Shared constants for the blinds motor controller.
// State encoding, time field layout and counter width helper.
package blinds_motor_controller_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_DEAD
    } blind_state_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    localparam int HOUR_MSB = 11;
    localparam int HOUR_LSB = 6;
    localparam int MIN_MSB  = 5;
    localparam int MIN_LSB  = 0;

    // Never return a zero-width counter for degenerate parameters
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blinds_channel_fsm.sv
// One blind channel: override timer, position counter,
// dead-time counter and motor FSM.
module blinds_channel_fsm
    import blinds_motor_controller_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 1000,
    parameter int DEAD_CYCLES   = 16,
    parameter int OVR_CYCLES    = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_auto_open,
    input  logic i_manual_req,
    input  logic i_manual_open,
    output logic o_motor_up,
    output logic o_motor_down,
    output logic o_status,
    output logic o_override
);

    localparam int POS_W  = cnt_width(TRAVEL_CYCLES + 1);
    localparam int OVR_W  = cnt_width(OVR_CYCLES);
    localparam int DEAD_W = cnt_width(DEAD_CYCLES + 1);

    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(TRAVEL_CYCLES);
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [OVR_W-1:0]  OVR_LOAD  = OVR_W'(OVR_CYCLES - 1);
    localparam logic [OVR_W-1:0]  OVR_ONE   = OVR_W'(1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

    logic              r_ovr;
    logic              r_ovr_dir;
    logic [OVR_W-1:0]  r_ovr_tmr;
    blind_state_e      r_state;
    logic [POS_W-1:0]  r_pos;
    logic [DEAD_W-1:0] r_dead;

    blind_state_e      w_state_n;
    logic [POS_W-1:0]  w_pos_n;
    logic [DEAD_W-1:0] w_dead_n;
    logic              w_target;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovr     <= 1'b0;
            r_ovr_dir <= 1'b0;
            r_ovr_tmr <= '0;
        end else if (i_manual_req) begin
            r_ovr     <= 1'b1;
            r_ovr_dir <= i_manual_open;
            r_ovr_tmr <= OVR_LOAD;
        end else if (r_ovr) begin
            if (r_ovr_tmr == '0) begin
                r_ovr <= 1'b0;
            end else begin
                r_ovr_tmr <= r_ovr_tmr - OVR_ONE;
            end
        end
    end

    assign w_target = r_ovr ? r_ovr_dir : i_auto_open;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CLOSED;
            r_pos   <= '0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_n;
            r_pos   <= w_pos_n;
            r_dead  <= w_dead_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pos_n   = r_pos;
        w_dead_n  = r_dead;
        unique case (r_state)
            ST_CLOSED: begin
                if (w_target) w_state_n = ST_OPENING;
            end
            ST_OPEN: begin
                if (!w_target) w_state_n = ST_CLOSING;
            end
            ST_OPENING: begin
                if (!w_target) begin
                    w_state_n = ST_DEAD;
                    w_dead_n  = DEAD_LOAD;
                end else if (r_pos >= POS_MAX - POS_ONE) begin
                    w_pos_n   = POS_MAX;
                    w_state_n = ST_OPEN;
                end else begin
                    w_pos_n = r_pos + POS_ONE;
                end
            end
            ST_CLOSING: begin
                if (w_target) begin
                    w_state_n = ST_DEAD;
                    w_dead_n  = DEAD_LOAD;
                end else if (r_pos <= POS_ONE) begin
                    w_pos_n   = '0;
                    w_state_n = ST_CLOSED;
                end else begin
                    w_pos_n = r_pos - POS_ONE;
                end
            end
            ST_DEAD: begin
                // Exit direction is sampled only when the dead time expires
                if (r_dead != '0) begin
                    w_dead_n = r_dead - DEAD_ONE;
                end else if (w_target) begin
                    w_state_n = (r_pos == POS_MAX) ? ST_OPEN : ST_OPENING;
                end else begin
                    w_state_n = (r_pos == '0) ? ST_CLOSED : ST_CLOSING;
                end
            end
            default: begin
                w_state_n = ST_CLOSED;
                w_pos_n   = '0;
            end
        endcase
    end

    always_comb begin
        o_motor_up   = (r_state == ST_OPENING);
        o_motor_down = (r_state == ST_CLOSING);
        o_status     = (r_state == ST_OPEN);
        o_override   = r_ovr;
    end

endmodule

// File: rtl/blinds_motor_controller.sv
// Multi-channel blinds controller: sample validation, sunlight
// hysteresis and the shared auto-open decision feeding each channel.
module blinds_motor_controller
    import blinds_motor_controller_pkg::*;
#(
    parameter int         NUM_CH         = 4,
    parameter int         TRAVEL_CYCLES  = 1000,
    parameter int         DEAD_CYCLES    = 16,
    parameter int         OVR_CYCLES     = 100000,
    parameter logic [7:0] LIGHT_OPEN_TH  = 8'd140,
    parameter logic [7:0] LIGHT_CLOSE_TH = 8'd116,
    parameter int         DAY_START_H    = 9,
    parameter int         DAY_END_H      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [11:0]       time_i,
    input  logic [7:0]        sunlight_level_i,
    input  logic [NUM_CH-1:0] manual_req_i,
    input  logic [NUM_CH-1:0] manual_open_i,
    output logic [NUM_CH-1:0] motor_up_o,
    output logic [NUM_CH-1:0] motor_down_o,
    output logic [NUM_CH-1:0] blinds_status_o,
    output logic [NUM_CH-1:0] override_o,
    output logic              time_err_o
);

    logic [5:0] w_hour;
    logic [5:0] w_min;
    logic       w_time_bad;
    logic       w_sample;
    logic       w_day;
    logic       w_light_ok_n;

    logic       r_light_ok;
    logic       r_auto_open;
    logic       r_time_err;

    assign w_hour     = time_i[HOUR_MSB:HOUR_LSB];
    assign w_min      = time_i[MIN_MSB:MIN_LSB];
    assign w_time_bad = (w_hour > 6'(HOUR_MAX)) || (w_min > 6'(MIN_MAX));
    assign w_sample   = valid_i && !w_time_bad;
    assign w_day      = (w_hour >= 6'(DAY_START_H))
                     && (w_hour <= 6'(DAY_END_H));

    always_comb begin
        w_light_ok_n = r_light_ok;
        if (sunlight_level_i > LIGHT_OPEN_TH) begin
            w_light_ok_n = 1'b1;
        end else if (sunlight_level_i < LIGHT_CLOSE_TH) begin
            w_light_ok_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_light_ok  <= 1'b0;
            r_auto_open <= 1'b0;
            r_time_err  <= 1'b0;
        end else begin
            r_time_err <= valid_i && w_time_bad;
            if (w_sample) begin
                r_light_ok  <= w_light_ok_n;
                r_auto_open <= w_day || w_light_ok_n;
            end
        end
    end

    assign time_err_o = r_time_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        blinds_channel_fsm #(
            .TRAVEL_CYCLES(TRAVEL_CYCLES),
            .DEAD_CYCLES  (DEAD_CYCLES),
            .OVR_CYCLES   (OVR_CYCLES)
        ) u_ch (
            .i_clk        (clk_i),
            .i_rst_n      (rst_ni),
            .i_auto_open  (r_auto_open),
            .i_manual_req (manual_req_i[g]),
            .i_manual_open(manual_open_i[g]),
            .o_motor_up   (motor_up_o[g]),
            .o_motor_down (motor_down_o[g]),
            .o_status     (blinds_status_o[g]),
            .o_override   (override_o[g])
        );
    end

endmodule

// File: tb/tb_blinds_motor_controller.sv
// Directed bench for blinds_motor_controller with a short travel,
// dead time and override window.
module tb_blinds_motor_controller;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       valid_i;
    logic [11:0] time_i;
    logic [7:0] sunlight_level_i;
    logic [1:0] manual_req_i;
    logic [1:0] manual_open_i;
    logic [1:0] motor_up_o;
    logic [1:0] motor_down_o;
    logic [1:0] blinds_status_o;
    logic [1:0] override_o;
    logic       time_err_o;

    int checks = 0;
    int errors = 0;

    blinds_motor_controller #(
        .NUM_CH       (2),
        .TRAVEL_CYCLES(8),
        .DEAD_CYCLES  (2),
        .OVR_CYCLES   (20)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .valid_i         (valid_i),
        .time_i          (time_i),
        .sunlight_level_i(sunlight_level_i),
        .manual_req_i    (manual_req_i),
        .manual_open_i   (manual_open_i),
        .motor_up_o      (motor_up_o),
        .motor_down_o    (motor_down_o),
        .blinds_status_o (blinds_status_o),
        .override_o      (override_o),
        .time_err_o      (time_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            checks++;
            if ((motor_up_o & motor_down_o) !== 2'b00) begin
                errors++;
                $display("FAIL both_lines: up=%b down=%b",
                         motor_up_o, motor_down_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [5:0] h, input logic [5:0] m,
                        input logic [7:0] l);
        valid_i          = 1'b1;
        time_i           = {h, m};
        sunlight_level_i = l;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic count_pat(input bit up, input logic [1:0] pat,
                             output int n);
        n = 0;
        while (((up ? motor_up_o : motor_down_o) === pat) && n < 100) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_ni           = 1'b0;
        valid_i          = 1'b0;
        time_i           = '0;
        sunlight_level_i = '0;
        manual_req_i     = '0;
        manual_open_i    = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({motor_up_o, motor_down_o, blinds_status_o, override_o,
             time_err_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got up=%b dn=%b st=%b ov=%b te=%b want all 0",
                     motor_up_o, motor_down_o, blinds_status_o,
                     override_o, time_err_o);
        end
    endtask

    task automatic test_day_open();
        int n;
        send(6'd10, 6'd0, 8'd0);
        checks++;
        if (motor_up_o !== 2'b00) begin
            errors++;
            $display("FAIL open_latency: up=%b want 00", motor_up_o);
        end
        @(negedge clk_i);
        count_pat(1'b1, 2'b11, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL day_open_cycles: got %0d want 8", n);
        end
        checks++;
        if (blinds_status_o !== 2'b11 || motor_up_o !== 2'b00) begin
            errors++;
            $display("FAIL day_open_status: st=%b up=%b want 11/00",
                     blinds_status_o, motor_up_o);
        end
    endtask

    task automatic test_light_hyst();
        int n;
        send(6'd22, 6'd0, 8'd0);
        @(negedge clk_i);
        count_pat(1'b0, 2'b11, n);
        checks++;
        if (n != 8 || blinds_status_o !== 2'b00) begin
            errors++;
            $display("FAIL night_close: cycles=%0d st=%b want 8/00",
                     n, blinds_status_o);
        end
        send(6'd22, 6'd0, 8'd150);
        @(negedge clk_i);
        count_pat(1'b1, 2'b11, n);
        checks++;
        if (n != 8 || blinds_status_o !== 2'b11) begin
            errors++;
            $display("FAIL light150_open: cycles=%0d st=%b want 8/11",
                     n, blinds_status_o);
        end
        send(6'd22, 6'd0, 8'd130);
        repeat (4) @(negedge clk_i);
        checks++;
        if (blinds_status_o !== 2'b11 || motor_down_o !== 2'b00) begin
            errors++;
            $display("FAIL light130_hold_open: st=%b dn=%b want 11/00",
                     blinds_status_o, motor_down_o);
        end
        send(6'd22, 6'd0, 8'd110);
        @(negedge clk_i);
        count_pat(1'b0, 2'b11, n);
        checks++;
        if (n != 8 || blinds_status_o !== 2'b00) begin
            errors++;
            $display("FAIL light110_close: cycles=%0d st=%b want 8/00",
                     n, blinds_status_o);
        end
        send(6'd22, 6'd0, 8'd130);
        repeat (4) @(negedge clk_i);
        checks++;
        if (blinds_status_o !== 2'b00 || motor_up_o !== 2'b00) begin
            errors++;
            $display("FAIL light130_hold_closed: st=%b up=%b want 00/00",
                     blinds_status_o, motor_up_o);
        end
    endtask

    task automatic test_reversal();
        int n;
        send(6'd10, 6'd0, 8'd0);
        @(negedge clk_i);
        count_pat(1'b1, 2'b11, n);
        send(6'd22, 6'd0, 8'd0);
        @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        checks++;
        if (motor_down_o !== 2'b11) begin
            errors++;
            $display("FAIL rev_closing: dn=%b want 11", motor_down_o);
        end
        send(6'd10, 6'd0, 8'd0);
        @(negedge clk_i);
        n = 0;
        while (motor_up_o === 2'b00 && motor_down_o === 2'b00 && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL rev_dead_cycles: got %0d want 2", n);
        end
        count_pat(1'b1, 2'b11, n);
        checks++;
        if (n != 3 || blinds_status_o !== 2'b11) begin
            errors++;
            $display("FAIL rev_reopen: cycles=%0d st=%b want 3/11",
                     n, blinds_status_o);
        end
    endtask

    task automatic run_override(input int rereq_at, input int len,
                                input int want_ovr);
        int ovr_n = 0;
        int dn_n  = 0;
        int up_n  = 0;
        int bad1  = 0;
        manual_req_i  = 2'b01;
        manual_open_i = 2'b00;
        @(negedge clk_i);
        manual_req_i = 2'b00;
        for (int i = 1; i <= len; i++) begin
            ovr_n += int'(override_o[0]);
            dn_n  += int'(motor_down_o[0]);
            up_n  += int'(motor_up_o[0]);
            if (override_o[1] !== 1'b0 || blinds_status_o[1] !== 1'b1)
                bad1++;
            manual_req_i = (i == rereq_at) ? 2'b01 : 2'b00;
            @(negedge clk_i);
        end
        manual_req_i = 2'b00;
        checks++;
        if (ovr_n != want_ovr) begin
            errors++;
            $display("FAIL ovr_len: got %0d want %0d", ovr_n, want_ovr);
        end
        checks++;
        if (dn_n != 8 || up_n != 8) begin
            errors++;
            $display("FAIL ovr_ch0_travel: dn=%0d up=%0d want 8/8",
                     dn_n, up_n);
        end
        checks++;
        if (bad1 != 0 || blinds_status_o !== 2'b11) begin
            errors++;
            $display("FAIL ovr_ch1_or_resume: bad=%0d st=%b want 0/11",
                     bad1, blinds_status_o);
        end
    endtask

    task automatic test_override();
        run_override(0, 45, 20);
        run_override(10, 55, 30);
    endtask

    task automatic test_time_err();
        int n;
        send(6'd24, 6'd0, 8'd0);
        checks++;
        if (time_err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_hour_pulse: got %b want 1", time_err_o);
        end
        @(negedge clk_i);
        checks++;
        if (time_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: got %b want 0", time_err_o);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (blinds_status_o !== 2'b11 || motor_down_o !== 2'b00) begin
            errors++;
            $display("FAIL err_hour_discard: st=%b dn=%b want 11/00",
                     blinds_status_o, motor_down_o);
        end
        send(6'd22, 6'd0, 8'd0);
        checks++;
        if (time_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_valid_time: got %b want 0", time_err_o);
        end
        @(negedge clk_i);
        count_pat(1'b0, 2'b11, n);
        send(6'd12, 6'd60, 8'd200);
        checks++;
        if (time_err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_min_pulse: got %b want 1", time_err_o);
        end
        repeat (5) @(negedge clk_i);
        checks++;
        if (blinds_status_o !== 2'b00 || motor_up_o !== 2'b00) begin
            errors++;
            $display("FAIL err_min_discard: st=%b up=%b want 00/00",
                     blinds_status_o, motor_up_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        send(6'd10, 6'd0, 8'd0);
        repeat (4) @(negedge clk_i);
        checks++;
        if (motor_up_o !== 2'b11) begin
            errors++;
            $display("FAIL mid_opening: up=%b want 11", motor_up_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (motor_up_o !== 2'b00 || motor_down_o !== 2'b00) begin
            errors++;
            $display("FAIL async_stop: up=%b dn=%b want 00/00",
                     motor_up_o, motor_down_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (blinds_status_o !== 2'b00 || motor_up_o !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_closed: st=%b up=%b want 00/00",
                     blinds_status_o, motor_up_o);
        end
        send(6'd10, 6'd0, 8'd0);
        @(negedge clk_i);
        count_pat(1'b1, 2'b11, n);
        checks++;
        if (n != 8 || blinds_status_o !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_pos0: cycles=%0d st=%b want 8/11",
                     n, blinds_status_o);
        end
    endtask

    initial begin
        test_reset();
        test_day_open();
        test_light_hyst();
        test_reversal();
        test_override();
        test_time_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
